// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// A grant lasts one burst: until the requester's last beat or MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic [DW-1:0]            wdata,
  output logic                     winc,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  // state | meaning
  // IDLE  | no owner; pick next valid requester after rr_q
  // BURST | grant_q owns the write port until last beat or MAX_BURST beats
  typedef enum logic {IDLE, BURST} state_t;

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  state_t           state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   pick, cand;
  logic             pick_vld;
  logic             xfer, burst_end;
  logic [DW-1:0]    data_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*DW +: DW];
    end
  end

  // Search starts one past the previous owner so it gets lowest priority.
  always_comb begin
    int idx;
    idx      = 0;
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  assign busy      = (state_q == BURST);
  assign grant_id  = grant_q;
  assign xfer      = busy & req_valid[grant_q] & ~wfull & ~wrst;
  assign burst_end = req_last[grant_q] | (cnt_q == CW'(MAX_BURST - 1));
  assign winc      = xfer;
  assign wdata     = (busy & ~wrst) ? data_arr[grant_q] : '0;

  always_comb begin
    req_ready = '0;
    if (busy & ~wfull & ~wrst) req_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          if (burst_end) begin
            state_d = IDLE;
            rr_d    = grant_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= IDW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
